// File: rtl/ddr_ref_pkg.sv
// Shared types and constants for the DDR refresh controller.
// Build option: define REF_POSTPONE_EN for 8-deep refresh postponement;
// without it a single owed refresh is already urgent.
package ddr_ref_pkg;

  localparam int TREFI_W = 16;
  localparam int TRFC_W  = 10;
  localparam int PEND_W  = 4;

`ifdef REF_POSTPONE_EN
  localparam logic [PEND_W-1:0] MAX_PENDING  = 4'd8;
  localparam logic [PEND_W-1:0] URGENT_LEVEL = 4'd8;
`else
  localparam logic [PEND_W-1:0] MAX_PENDING  = 4'd1;
  localparam logic [PEND_W-1:0] URGENT_LEVEL = 4'd1;
`endif

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_IDLE      = 2'd1,
    ST_REQ       = 2'd2,
    ST_TRFC      = 2'd3
  } ref_state_e;

endpackage

// File: rtl/ref_interval_timer.sv
// Free-running tREFI interval counter. Counts 0..i_trefi-1 while i_run is
// high and pulses o_tick (combinationally) on the wrap cycle. Held at 0
// while i_run is low or when i_trefi is 0 (refresh disabled).
module ref_interval_timer
  import ddr_ref_pkg::*;
(
  input  logic               core_clk,
  input  logic               core_arstn,
  input  logic               i_run,
  input  logic [TREFI_W-1:0] i_trefi,
  output logic               o_tick
);

  localparam logic [TREFI_W-1:0] ONE = 1;

  logic [TREFI_W-1:0] r_cnt;
  logic               w_enabled;
  logic               w_wrap;

  assign w_enabled = i_run && (i_trefi != '0);
  // >= keeps the counter bounded even if the interval were shortened mid-count
  assign w_wrap    = (r_cnt >= (i_trefi - ONE));
  assign o_tick    = w_enabled && w_wrap;

  // Interval count: restart from 0 when stopped, disabled or wrapping
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      r_cnt <= '0;
    end else if (!w_enabled || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/refresh_control.sv
// DDR refresh controller: accumulates owed refreshes from the tREFI timer,
// requests REF from the scheduler, and holds off traffic for tRFC.
// Handshake: ref_req is high exactly while in REQ; a REF is taken on any
// cycle where ref_req=1 and ref_ack=1. ref_ack in any other state is ignored.
// Build option: REF_POSTPONE_EN (see ddr_ref_pkg).
module refresh_control
  import ddr_ref_pkg::*;
(
  input  logic               core_clk,
  input  logic               core_arstn,
  input  logic               ddr_init_done,
  input  logic [TREFI_W-1:0] cfg_trefi,
  input  logic [TRFC_W-1:0]  cfg_trfc,
  output logic               ref_req,
  input  logic               ref_ack,
  output logic               ref_urgent,
  output logic               ref_busy,
  output logic [PEND_W-1:0]  ref_pending,
  output logic               ref_overflow,
  output logic [1:0]         o_dbg_state
);

  localparam logic [PEND_W-1:0] PEND_ONE = 1;
  localparam logic [TRFC_W-1:0] TRFC_ONE = 1;

  ref_state_e         r_state;
  ref_state_e         w_state_next;
  logic [TRFC_W-1:0]  r_trfc_cnt;
  logic [TRFC_W-1:0]  w_trfc_next;
  logic [PEND_W-1:0]  r_pending;
  logic [PEND_W-1:0]  w_pend_next;
  logic               r_req;
  logic               r_busy;
  logic               r_urgent;
  logic               r_overflow;
  logic               w_tick;
  logic               w_ack;
  logic               w_ovf_set;

  ref_interval_timer u_timer (
    .core_clk   (core_clk),
    .core_arstn (core_arstn),
    .i_run      (ddr_init_done),
    .i_trefi    (cfg_trefi),
    .o_tick     (w_tick)
  );

  assign w_ack = ref_ack && (r_state == ST_REQ);

  // Owed-refresh bookkeeping: tick adds, accepted REF removes, both cancel
  always_comb begin
    w_pend_next = r_pending;
    w_ovf_set   = 1'b0;
    if (w_tick && !w_ack) begin
      if (r_pending == MAX_PENDING) begin
        w_ovf_set = 1'b1;
      end else begin
        w_pend_next = r_pending + PEND_ONE;
      end
    end else if (w_ack && !w_tick && (r_pending != '0)) begin
      w_pend_next = r_pending - PEND_ONE;
    end
  end

  // Next state and tRFC countdown; losing init_done overrides everything
  always_comb begin
    w_state_next = r_state;
    w_trfc_next  = r_trfc_cnt;
    unique case (r_state)
      ST_WAIT_INIT: w_state_next = ST_IDLE;
      ST_IDLE: begin
        if (r_pending != '0) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (ref_ack) begin
          w_state_next = ST_TRFC;
          w_trfc_next  = cfg_trfc;
        end
      end
      ST_TRFC: begin
        if (r_trfc_cnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_trfc_next = r_trfc_cnt - TRFC_ONE;
        end
      end
      default: w_state_next = ST_WAIT_INIT;
    endcase
    if (!ddr_init_done) begin
      w_state_next = ST_WAIT_INIT;
      w_trfc_next  = '0;
    end
  end

  // Registered state, counters and outputs; overflow survives init loss
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      r_state    <= ST_WAIT_INIT;
      r_trfc_cnt <= '0;
      r_pending  <= '0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_urgent   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_trfc_cnt <= w_trfc_next;
      r_req      <= (w_state_next == ST_REQ);
      r_busy     <= (w_state_next == ST_TRFC);
      if (ddr_init_done) begin
        r_pending  <= w_pend_next;
        r_urgent   <= (w_pend_next >= URGENT_LEVEL);
        r_overflow <= r_overflow | w_ovf_set;
      end else begin
        r_pending  <= '0;
        r_urgent   <= 1'b0;
      end
    end
  end

  assign ref_req      = r_req;
  assign ref_busy     = r_busy;
  assign ref_urgent   = r_urgent;
  assign ref_pending  = r_pending;
  assign ref_overflow = r_overflow;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/refresh_control.md
REFRESH_CONTROL -- requirements
Module: refresh_control

Interface
REQ-001 SHALL have port core_clk, input, 1 bit: core clock; all logic is rising-edge.
REQ-002 SHALL have port core_arstn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ddr_init_done, input, 1 bit: DRAM initialization complete; level signal.
REQ-004 SHALL have port cfg_trefi, input, 16 bits: refresh interval tREFI in core_clk cycles.
REQ-005 SHALL have port cfg_trfc, input, 10 bits: refresh cycle time tRFC in core_clk cycles.
REQ-006 SHALL have port ref_req, output, 1 bit: refresh request to command scheduler.
REQ-007 SHALL have port ref_ack, input, 1 bit: scheduler issued REF this cycle.
REQ-008 SHALL have port ref_urgent, output, 1 bit: postponement limit reached; scheduler must stop new traffic.
REQ-009 SHALL have port ref_busy, output, 1 bit: tRFC window active; no commands to DRAM.
REQ-010 SHALL have port ref_pending, output, 4 bits: owed refreshes, 0..8.
REQ-011 SHALL have port ref_overflow, output, 1 bit: sticky; a tick was lost at saturation.

Function
REQ-012 SHALL implement FSM states WAIT_INIT, IDLE, REQ, TRFC.
REQ-013 WAIT_INIT -> IDLE on the first cycle with ddr_init_done=1; interval counter begins at 0 on that cycle.
REQ-014 Interval counter SHALL count 0..cfg_trefi-1 in IDLE/REQ/TRFC, then wrap to 0 and generate one tick.
REQ-015 cfg_trefi=0 SHALL suppress all ticks (refresh disabled); cfg inputs change only while ddr_init_done=0.
REQ-016 Tick SHALL increment ref_pending, saturating at MAX_PENDING; a tick at saturation sets ref_overflow.
REQ-017 IDLE -> REQ when ref_pending != 0; ref_req = 1 exactly in REQ; ref_req is registered.
REQ-018 In REQ, ref_ack=1 SHALL decrement ref_pending, load tRFC counter with cfg_trfc, and move to TRFC next cycle.
REQ-019 Tick and ack in same cycle: ref_pending unchanged; no overflow, even at saturation.
REQ-020 ref_ack outside REQ SHALL be ignored.
REQ-021 TRFC: ref_busy=1; counter decrements each cycle; at 0 -> IDLE; cfg_trfc=0 gives one TRFC cycle.
REQ-022 Back-to-back: TRFC -> IDLE -> REQ when pending remains, so ref_req rises 2 cycles after TRFC ends.
REQ-023 ref_urgent SHALL equal (ref_pending >= URGENT_LEVEL), registered with ref_pending.
REQ-024 ddr_init_done falling in any state SHALL force WAIT_INIT next cycle and clear all counters, pending and outputs except ref_overflow.

Reset
REQ-025 On core_arstn=0: state WAIT_INIT; ref_req, ref_urgent, ref_busy, ref_overflow = 0; ref_pending = 0; both counters 0.
REQ-026 Reset deassertion SHALL take effect on the next core_clk edge; no REF issued before ddr_init_done.

Configuration
REQ-027 Macro REF_POSTPONE_EN defined: MAX_PENDING=8, URGENT_LEVEL=8 (JEDEC 8-deep postponement).
REQ-028 Macro REF_POSTPONE_EN undefined: MAX_PENDING=1, URGENT_LEVEL=1; ref_urgent asserts on every owed refresh.

Structure
REQ-029 Package ddr_ref_pkg SHALL hold the state enum, MAX_PENDING, URGENT_LEVEL, TREFI_W=16, TRFC_W=10.
REQ-030 One sub-module, ref_interval_timer (free-running wrap counter with tick output), SHALL implement REQ-014/015.

Verification
REQ-031 Reset, ddr_init_done=0 for 1000 cycles, cfg_trefi=100 -> ref_req never asserts, ref_pending=0.
REQ-032 cfg_trefi=100, cfg_trfc=20, init_done rises at cycle T, ack one cycle after req -> ref_req at T+101, ref_busy high for 21 cycles.
REQ-033 REF_POSTPONE_EN, cfg_trefi=10, ref_ack held 0 -> ref_pending reaches 8 after 80 cycles, ref_urgent=1; 9th tick sets ref_overflow.
REQ-034 Pending=8, tick coincident with ack -> ref_pending stays 8, ref_overflow stays 0, then 7 after next non-tick ack.
REQ-035 Drop ddr_init_done during TRFC -> next cycle WAIT_INIT, ref_busy=0, ref_pending=0; re-assert restarts interval from 0.
REQ-036 Macro undefined, cfg_trefi=10, no ack -> ref_pending=1, ref_urgent=1 after 10 cycles; ref_overflow set at cycle 20.
